btn_bounce_gen: RTL and testbench
=================================

BTN_BOUNCE_GEN -- requirements
Module: btn_bounce_gen

Interface
REQ-001 Parameter BOUNCE_CYCLES, default 8: number of chatter cycles per level transition (legal range >= 1).
REQ-002 Parameter SETTLE_CYCLES, default 4: number of stable cycles after chatter before completion (legal range >= 1).
REQ-003 Parameter SEED, default 16'h84C1: LFSR initial value; a value of 16'h0000 SHALL be replaced by 16'hACE1.
REQ-004 Parameter IDLE_LEVEL, default 1'b0: out_line level after reset.
REQ-005 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-006 reset  input  1  asynchronous, active-high reset.
REQ-007 cmd_valid  input  1  request for a transition to cmd_level.
REQ-008 cmd_level  input  1  target stable level of the emulated switch.
REQ-009 cmd_ready  output  1  high only in IDLE; a command is accepted on an edge where cmd_valid && cmd_ready.
REQ-010 out_line  output  1  registered emulated raw switch line, intended to drive btn_fltr in_signal.
REQ-011 busy  output  1  high whenever the state is not IDLE.
REQ-012 done  output  1  one-cycle pulse on completion of a command.

Function
REQ-013 The FSM SHALL have exactly three states: IDLE, BOUNCE and SETTLE.
REQ-014 IDLE: out_line SHALL hold the last stable level; on acceptance with cmd_level != stable level, go to BOUNCE with the counter loaded to BOUNCE_CYCLES.
REQ-015 IDLE: on acceptance with cmd_level == stable level, skip chatter and go to SETTLE with the counter loaded to SETTLE_CYCLES.
REQ-016 BOUNCE: each cycle, the 16-bit Galois LFSR (x^16+x^14+x^13+x^11+1) SHALL advance once, and out_line SHALL take bit 0 of the new LFSR value.
REQ-017 When the BOUNCE counter expires, go to SETTLE and load SETTLE_CYCLES.
REQ-018 SETTLE: out_line SHALL equal the target level every cycle.
REQ-019 When the SETTLE counter expires, go to IDLE, update the stable level to the target, and assert done for exactly that first IDLE cycle.
REQ-020 Timing for a level-changing command accepted at edge 0: chatter occupies cycles 1..BOUNCE_CYCLES, settle occupies the next SETTLE_CYCLES cycles, and done is high in cycle BOUNCE_CYCLES+SETTLE_CYCLES+1.
REQ-021 The LFSR SHALL advance only in BOUNCE, so the chatter sequence is deterministic for a given SEED and command history.
REQ-022 cmd_valid while busy SHALL be ignored; no queueing is performed.
REQ-023 A command held valid SHALL be accepted in the done cycle, because cmd_ready is already high then.
REQ-024 cmd_level SHALL be sampled only at acceptance; later changes SHALL have no effect on the active command.
REQ-025 Counter widths SHALL be $clog2(max(BOUNCE_CYCLES, SETTLE_CYCLES) + 1) bits, and the counters SHALL never wrap below zero.

Reset
REQ-026 On reset assertion, asynchronously: state = IDLE, out_line = IDLE_LEVEL, stable level = IDLE_LEVEL, LFSR = SEED (or the zero-seed substitute), counter = 0.
REQ-027 Output values during reset: busy = 0, done = 0, cmd_ready = 1.
REQ-028 Reset asserted mid-BOUNCE or mid-SETTLE SHALL abort the command without a done pulse.
REQ-029 The first accepted command after reset release SHALL be processed normally.

Structure
REQ-030 The state encodings, the LFSR tap mask 16'hB400 and the zero-seed substitute 16'hACE1 SHALL reside in a shared package or include file common to the button blocks.
REQ-031 The LFSR SHALL be a separate sub-module, lfsr16, with ports clk, reset, en, seed and value.
REQ-032 The FSM and counters SHALL stay in btn_bounce_gen.

Verification
REQ-033 Reset release, then command cmd_level=1 -> out_line chatters for 8 cycles, then reads 1 for 4 cycles, then done is pulsed in cycle 13 after acceptance.
REQ-034 Command cmd_level=0 while the stable level is 0 -> no chatter; out_line stays 0; done is pulsed in cycle 5.
REQ-035 cmd_valid held high across completion -> the second command is accepted in the done cycle, with no idle gap.
REQ-036 Reset asserted in BOUNCE cycle 3 -> out_line = 0 and busy = 0 immediately, with no done pulse; repeating the same command reproduces an identical chatter sequence.
REQ-037 SEED = 0 -> behaviour is identical to SEED = 16'hACE1.
REQ-038 Chain: out_line feeds btn_fltr -> its filtered output changes exactly once per level-changing command and never during chatter.

Source files
------------

// File: rtl/btn_bounce_gen_pkg.sv
// rtl/btn_bounce_gen_pkg.sv - shared types, constants and LFSR step for the button blocks
//
// Purpose: state encoding of the bounce generator FSM, the 16-bit Galois LFSR
//          tap mask and zero-seed substitute, and pure helper functions.
// Ports:   none (package).

package btn_bounce_gen_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_BOUNCE = 2'd1,
        ST_SETTLE = 2'd2
    } bounce_state_t;

    // x^16 + x^14 + x^13 + x^11 + 1, right-shifting Galois form
    localparam logic [15:0] LFSR_TAP_MASK  = 16'hB400;
    // An all-zero LFSR never leaves zero, so a zero seed is swapped for this
    localparam logic [15:0] LFSR_ZERO_SEED = 16'hACE1;

    function automatic logic [15:0] lfsr_step(input logic [15:0] value);
        lfsr_step = {1'b0, value[15:1]} ^ (value[0] ? LFSR_TAP_MASK : 16'h0000);
    endfunction

    function automatic logic [15:0] lfsr_seed_fix(input logic [15:0] seed);
        lfsr_seed_fix = (seed == 16'h0000) ? LFSR_ZERO_SEED : seed;
    endfunction

endpackage

// File: rtl/btn_bounce_gen_lfsr16.sv
// rtl/btn_bounce_gen_lfsr16.sv - 16-bit Galois LFSR used as the chatter source
//
// Purpose: holds the LFSR state; advances one step on each enabled clock.
// Ports:   clk   - clock, rising edge
//          reset - asynchronous active-high reset, loads seed (zero replaced)
//          en    - advance the LFSR this cycle
//          seed  - reset value
//          value - current LFSR state

module lfsr16
    import btn_bounce_gen_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        en,
    input  logic [15:0] seed,
    output logic [15:0] value
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            value <= lfsr_seed_fix(seed);
        end else if (en) begin
            value <= lfsr_step(value);
        end
    end

endmodule

// File: rtl/btn_bounce_gen.sv
// rtl/btn_bounce_gen.sv - emulated bouncing push-button line generator
//
// Purpose: on a command, drives out_line through a pseudo-random chatter phase
//          (only when the level changes), then a stable settle phase at the
//          target level, then pulses done for one cycle.
// Ports:   clk       - clock, rising edge
//          reset     - asynchronous active-high reset
//          cmd_valid - request a transition to cmd_level
//          cmd_level - target stable level, sampled at acceptance only
//          cmd_ready - high in IDLE; accept on cmd_valid && cmd_ready
//          out_line  - registered emulated raw switch line
//          busy      - high whenever not IDLE
//          done      - one-cycle completion pulse

module btn_bounce_gen
    import btn_bounce_gen_pkg::*;
#(
    parameter int          BOUNCE_CYCLES = 8,
    parameter int          SETTLE_CYCLES = 4,
    parameter logic [15:0] SEED          = 16'h84C1,
    parameter logic        IDLE_LEVEL    = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic cmd_valid,
    input  logic cmd_level,
    output logic cmd_ready,
    output logic out_line,
    output logic busy,
    output logic done
);

    localparam int MAX_CYCLES = (BOUNCE_CYCLES > SETTLE_CYCLES) ? BOUNCE_CYCLES : SETTLE_CYCLES;
    localparam int CW         = $clog2(MAX_CYCLES + 1);

    localparam logic [CW-1:0] BOUNCE_LOAD = CW'(BOUNCE_CYCLES);
    localparam logic [CW-1:0] SETTLE_LOAD = CW'(SETTLE_CYCLES);
    localparam logic [CW-1:0] CNT_ONE     = CW'(1);
    localparam logic [CW-1:0] CNT_ZERO    = '0;

    bounce_state_t state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          out_q, out_d;
    logic          stable_q, stable_d;
    logic          target_q, target_d;
    logic          done_q, done_d;

    logic          lfsr_en;
    logic [15:0]   lfsr_value;
    logic [15:0]   lfsr_next;

    lfsr16 u_lfsr (
        .clk   (clk),
        .reset (reset),
        .en    (lfsr_en),
        .seed  (SEED),
        .value (lfsr_value)
    );

    // out_line is registered, so the chatter bit for the next cycle is the
    // bit the LFSR will hold after this edge's step.
    assign lfsr_next = lfsr_step(lfsr_value);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            cnt_q    <= CNT_ZERO;
            out_q    <= IDLE_LEVEL;
            stable_q <= IDLE_LEVEL;
            target_q <= IDLE_LEVEL;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            out_q    <= out_d;
            stable_q <= stable_d;
            target_q <= target_d;
            done_q   <= done_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        out_d    = out_q;
        stable_d = stable_q;
        target_d = target_q;
        done_d   = 1'b0;
        lfsr_en  = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    target_d = cmd_level;
                    if (cmd_level != stable_q) begin
                        // The step taken on the accepting edge produces the
                        // first chatter cycle's value; it belongs to BOUNCE.
                        state_d = ST_BOUNCE;
                        cnt_d   = BOUNCE_LOAD;
                        lfsr_en = 1'b1;
                        out_d   = lfsr_next[0];
                    end else begin
                        state_d = ST_SETTLE;
                        cnt_d   = SETTLE_LOAD;
                        out_d   = cmd_level;
                    end
                end
            end

            ST_BOUNCE: begin
                if (cnt_q <= CNT_ONE) begin
                    state_d = ST_SETTLE;
                    cnt_d   = SETTLE_LOAD;
                    out_d   = target_q;
                end else begin
                    cnt_d   = cnt_q - CNT_ONE;
                    lfsr_en = 1'b1;
                    out_d   = lfsr_next[0];
                end
            end

            ST_SETTLE: begin
                out_d = target_q;
                if (cnt_q <= CNT_ONE) begin
                    state_d  = ST_IDLE;
                    cnt_d    = CNT_ZERO;
                    stable_d = target_q;
                    done_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end

            default: begin
                state_d = ST_IDLE;
                cnt_d   = CNT_ZERO;
            end
        endcase
    end

    assign cmd_ready = (state_q == ST_IDLE);
    assign busy      = (state_q != ST_IDLE);
    assign out_line  = out_q;
    assign done      = done_q;

endmodule

// File: tb/tb_btn_bounce_gen.sv
// tb/tb_btn_bounce_gen.sv - self-checking bench for btn_bounce_gen

module tb_btn_bounce_gen;

    localparam int          B      = 8;
    localparam int          S      = 4;
    localparam logic [15:0] SEED_A = 16'h84C1;
    localparam logic [15:0] SEED_Z = 16'hACE1;

    logic       clk = 1'b0;
    logic       reset;
    logic       cmd_valid;
    logic       cmd_level;
    logic [1:0] ready;
    logic [1:0] out;
    logic [1:0] busy;
    logic [1:0] done;

    int vectors     = 0;
    int miscompares = 0;

    logic [15:0] m_lfsr [2];
    logic        m_stable [2];

    always #5 clk = ~clk;

    btn_bounce_gen dut_a (
        .clk       (clk),
        .reset     (reset),
        .cmd_valid (cmd_valid),
        .cmd_level (cmd_level),
        .cmd_ready (ready[0]),
        .out_line  (out[0]),
        .busy      (busy[0]),
        .done      (done[0])
    );

    btn_bounce_gen #(.SEED(16'h0000)) dut_z (
        .clk       (clk),
        .reset     (reset),
        .cmd_valid (cmd_valid),
        .cmd_level (cmd_level),
        .cmd_ready (ready[1]),
        .out_line  (out[1]),
        .busy      (busy[1]),
        .done      (done[1])
    );

    // x^16+x^14+x^13+x^11+1 in right-shift Galois form
    function automatic logic [15:0] model_step(input logic [15:0] v);
        logic [15:0] n;
        n = v >> 1;
        if (v[0]) n = n ^ 16'hB400;
        return n;
    endfunction

    task automatic model_reset();
        m_lfsr[0]   = SEED_A;
        m_lfsr[1]   = SEED_Z;
        m_stable[0] = 1'b0;
        m_stable[1] = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        model_reset();
    endtask

    // One command, checked every cycle from acceptance through the done cycle.
    task automatic run_cmd(input logic lvl, input bit noise, input bit pre_driven,
                           input bit chain, input logic next_lvl, input string tag);
        logic exp_o [2][64];
        int   total;
        int   n_ch;
        if (!pre_driven) begin
            @(negedge clk);
            cmd_valid = 1'b1;
            cmd_level = lvl;
        end
        total = 0;
        for (int d = 0; d < 2; d++) begin
            n_ch  = (lvl !== m_stable[d]) ? B : 0;
            total = n_ch + S + 1;
            for (int k = 1; k <= total; k++) begin
                if (k <= n_ch) begin
                    m_lfsr[d]   = model_step(m_lfsr[d]);
                    exp_o[d][k] = m_lfsr[d][0];
                end else begin
                    exp_o[d][k] = lvl;
                end
            end
            m_stable[d] = lvl;
        end
        @(posedge clk);
        #1;
        cmd_valid = noise ? 1'($urandom) : 1'b0;
        cmd_level = 1'($urandom);
        for (int k = 1; k <= total; k++) begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                vectors += 4;
                if (out[d] !== exp_o[d][k]) begin
                    miscompares++;
                    $display("FAIL %s out_line dut%0d cycle %0d got %b exp %b", tag, d, k, out[d], exp_o[d][k]);
                end
                if (busy[d] !== (k < total)) begin
                    miscompares++;
                    $display("FAIL %s busy dut%0d cycle %0d got %b exp %b", tag, d, k, busy[d], (k < total));
                end
                if (done[d] !== (k == total)) begin
                    miscompares++;
                    $display("FAIL %s done dut%0d cycle %0d got %b exp %b", tag, d, k, done[d], (k == total));
                end
                if (ready[d] !== (k == total)) begin
                    miscompares++;
                    $display("FAIL %s cmd_ready dut%0d cycle %0d got %b exp %b", tag, d, k, ready[d], (k == total));
                end
            end
            if (k < total) begin
                cmd_valid = noise ? 1'($urandom) : 1'b0;
                cmd_level = 1'($urandom);
            end else if (chain) begin
                cmd_valid = 1'b1;
                cmd_level = next_lvl;
            end else begin
                cmd_valid = 1'b0;
            end
        end
    endtask

    task automatic test_reset();
        reset     = 1'b1;
        cmd_valid = 1'b1;
        cmd_level = 1'b1;
        repeat (2) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            vectors += 4;
            if (ready[d] !== 1'b1) begin miscompares++; $display("FAIL reset cmd_ready dut%0d got %b exp 1", d, ready[d]); end
            if (busy[d] !== 1'b0) begin miscompares++; $display("FAIL reset busy dut%0d got %b exp 0", d, busy[d]); end
            if (done[d] !== 1'b0) begin miscompares++; $display("FAIL reset done dut%0d got %b exp 0", d, done[d]); end
            if (out[d] !== 1'b0) begin miscompares++; $display("FAIL reset out_line dut%0d got %b exp 0", d, out[d]); end
        end
        cmd_valid = 1'b0;
        cmd_level = 1'b0;
        reset     = 1'b0;
        model_reset();
    endtask

    task automatic test_rise();
        run_cmd(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "rise");
    endtask

    task automatic test_fall_and_same_level();
        run_cmd(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "fall");
        run_cmd(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "same_level");
    endtask

    task automatic test_back_to_back();
        run_cmd(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, "b2b_first");
        run_cmd(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, "b2b_second");
        run_cmd(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, "b2b_third");
        run_cmd(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, "b2b_fourth");
    endtask

    task automatic test_reset_abort();
        do_reset();
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_level = 1'b1;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        cmd_level = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                m_lfsr[d] = model_step(m_lfsr[d]);
                vectors += 2;
                if (out[d] !== m_lfsr[d][0]) begin
                    miscompares++;
                    $display("FAIL abort_chatter dut%0d cycle %0d got %b exp %b", d, k, out[d], m_lfsr[d][0]);
                end
                if (busy[d] !== 1'b1) begin
                    miscompares++;
                    $display("FAIL abort_busy dut%0d cycle %0d got %b exp 1", d, k, busy[d]);
                end
            end
        end
        reset = 1'b1;
        #1;
        for (int d = 0; d < 2; d++) begin
            vectors += 3;
            if (out[d] !== 1'b0) begin miscompares++; $display("FAIL abort_out dut%0d got %b exp 0", d, out[d]); end
            if (busy[d] !== 1'b0) begin miscompares++; $display("FAIL abort_busy_rst dut%0d got %b exp 0", d, busy[d]); end
            if (done[d] !== 1'b0) begin miscompares++; $display("FAIL abort_done dut%0d got %b exp 0", d, done[d]); end
        end
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                vectors += 2;
                if (done[d] !== 1'b0) begin miscompares++; $display("FAIL abort_no_done dut%0d got %b exp 0", d, done[d]); end
                if (out[d] !== 1'b0) begin miscompares++; $display("FAIL abort_idle_out dut%0d got %b exp 0", d, out[d]); end
            end
        end
        run_cmd(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "abort_repeat");
    endtask

    task automatic test_random();
        for (int i = 0; i < 24; i++) begin
            run_cmd(1'($urandom), 1'($urandom), 1'b0, 1'b0, 1'b0, "random");
            repeat ($urandom_range(0, 2)) begin
                @(negedge clk);
                for (int d = 0; d < 2; d++) begin
                    vectors += 3;
                    if (ready[d] !== 1'b1) begin miscompares++; $display("FAIL idle_ready dut%0d got %b exp 1", d, ready[d]); end
                    if (done[d] !== 1'b0) begin miscompares++; $display("FAIL idle_done dut%0d got %b exp 0", d, done[d]); end
                    if (out[d] !== m_stable[d]) begin miscompares++; $display("FAIL idle_out dut%0d got %b exp %b", d, out[d], m_stable[d]); end
                end
            end
        end
    endtask

    initial begin
        reset     = 1'b1;
        cmd_valid = 1'b0;
        cmd_level = 1'b0;
        model_reset();
        test_reset();
        test_rise();
        test_fall_and_same_level();
        test_back_to_back();
        test_reset_abort();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
